odo_sbox_small_inv: RTL
=======================

ODO_SBOX_SMALL_INV -- requirements
Module: odo_sbox_small_inv

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port load_start, input, 1 bit: pulse that begins a new forward-table load.
REQ-004 The block SHALL have the port load_valid, input, 1 bit: forward entry present on load_addr/load_data.
REQ-005 The block SHALL have the port load_addr, input, 6 bits: forward S-box input (index).
REQ-006 The block SHALL have the port load_data, input, 6 bits: forward S-box output at load_addr.
REQ-007 The block SHALL have the port load_ready, output, 1 bit: high while in LOADING, so entries are accepted.
REQ-008 The block SHALL have the port lk_valid, input, 1 bit: inverse lookup request.
REQ-009 The block SHALL have the port lk_in, input, 6 bits: value to invert.
REQ-010 The block SHALL have the port lk_out, output, 6 bits: registered inverse result.
REQ-011 The block SHALL have the port lk_out_valid, output, 1 bit: lk_out is valid this cycle.
REQ-012 The block SHALL have the port tbl_ready, output, 1 bit: the inverse table is complete and valid.
REQ-013 The block SHALL have the port tbl_error, output, 1 bit: the last load was not a permutation.

Function
REQ-014 The FSM SHALL have the states EMPTY, LOADING, READY and ERROR, and SHALL enter EMPTY after reset.
REQ-015 load_start in any state SHALL, on the next edge, enter LOADING, zero the 7-bit entry counter, and clear both 64-bit bitmaps seen_addr and seen_data.
REQ-016 In LOADING, load_valid SHALL write inv[load_data] <= load_addr, set seen_addr[load_addr] and seen_data[load_data], and increment the counter, one entry per cycle with no stall.
REQ-017 A write whose addr or data bit is already set SHALL latch an internal dup flag; the write SHALL still occur.
REQ-018 On the edge accepting the 64th entry, the FSM SHALL go to READY if dup is clear (including this entry), else to ERROR.
REQ-019 load_valid outside LOADING SHALL be ignored, and load_valid together with load_start SHALL be dropped.
REQ-020 tbl_ready SHALL equal (state==READY), tbl_error SHALL equal (state==ERROR), and load_ready SHALL equal (state==LOADING), all as registered state decodes.
REQ-021 Lookup latency SHALL be 1 cycle: lk_valid at edge N in READY gives lk_out=inv[lk_in] and lk_out_valid=1 after edge N.
REQ-022 Lookup throughput SHALL be 1 per cycle, back-to-back.
REQ-023 lk_valid in EMPTY, LOADING or ERROR SHALL yield lk_out_valid=0 and SHALL hold lk_out at its previous value.
REQ-024 When lk_valid and load_start occur together, load_start SHALL win, the lookup SHALL be dropped, and lk_out_valid SHALL be 0.
REQ-025 The counter SHALL saturate semantics by state: it SHALL not increment outside LOADING, and SHALL never wrap.

Reset
REQ-026 rst SHALL set state=EMPTY, counter=0, bitmaps=0, dup=0, lk_out=6'h00 and lk_out_valid=0, with rst taking priority over all inputs.
REQ-027 The inv table contents SHALL not be reset, and SHALL be don't-care until a full valid load completes.
REQ-028 rst mid-load SHALL abandon the load, with tbl_ready=0 until a fresh complete load.

Structure
REQ-029 Package odo_pkg SHALL hold SBOX6_W=6, SBOX6_N=64, and the FSM state enum.
REQ-030 The inv storage SHALL be the sub-module odo_ram64x6: 64x6, one synchronous write port and one synchronous read port, with no reset and no initial contents.
REQ-031 The FSM, counter, bitmaps and dup flag SHALL reside in odo_sbox_small_inv.

Verification
REQ-032 Load the identity map (addr=data=0..63), then look up 0x2F, which SHALL give lk_out=0x2F one cycle later with tbl_ready=1.
REQ-033 Load a permutation containing 0->0x20, 1->0x2F and 63->0x06, then look up 0x20, 0x2F and 0x06 on consecutive cycles, which SHALL give 0x00, 0x01 and 0x3F on consecutive cycles.
REQ-034 Load a table with entries 4->0x03 and 5->0x03, which SHALL give tbl_error=1 after the 64th entry and lk_out_valid=0 for every lookup.
REQ-035 Assert rst after 30 entries, which SHALL give tbl_ready=0, load_ready=0, and lk_valid yielding no lk_out_valid.
REQ-036 Restart a load with load_start after 40 entries and then feed 64 distinct entries, which SHALL give READY exactly on the 64th new entry with no false error.
REQ-037 Assert load_start with lk_valid in READY, which SHALL give lk_out_valid=0 and load_ready=1 next cycle.

Source files
------------

// File: rtl/odo_pkg.sv
// Shared widths and FSM state encoding for the 6-bit inverse S-box block.
package odo_pkg;

    localparam int SBOX6_W = 6;
    localparam int SBOX6_N = 64;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {
        EMPTY,
        LOADING,
        READY,
        ERROR
    } state_t;

endpackage

// File: rtl/odo_ram64x6.sv
// 64x6 storage for the inverse table: one synchronous write port and one
// synchronous read port. No reset and no initial contents.
module odo_ram64x6
    import odo_pkg::*;
(
    input  logic               clk,
    input  logic               we,
    input  logic [SBOX6_W-1:0] waddr,
    input  logic [SBOX6_W-1:0] wdata,
    input  logic               re,
    input  logic [SBOX6_W-1:0] raddr,
    output logic [SBOX6_W-1:0] rdata
);

    logic [SBOX6_W-1:0] mem [SBOX6_N];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/odo_sbox_small_inv.sv
// Builds an inverse 6-bit S-box from a streamed forward table, checks that the
// forward table is a permutation, and serves 1-cycle inverse lookups.
module odo_sbox_small_inv
    import odo_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [SBOX6_W-1:0] load_addr,
    input  logic [SBOX6_W-1:0] load_data,
    output logic               load_ready,
    input  logic               lk_valid,
    input  logic [SBOX6_W-1:0] lk_in,
    output logic [SBOX6_W-1:0] lk_out,
    output logic               lk_out_valid,
    output logic               tbl_ready,
    output logic               tbl_error
);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [SBOX6_N-1:0] seen_addr;
    logic [SBOX6_N-1:0] seen_data;
    logic               dup;
    logic               out_zero;
    logic               accept;
    logic               hit;
    logic               last;
    logic               lookup;
    logic [SBOX6_W-1:0] ram_q;

    assign accept = (state == LOADING) && load_valid && !load_start;
    assign hit    = seen_addr[load_addr] | seen_data[load_data];
    assign last   = (cnt == CNT_W'(SBOX6_N - 1));
    assign lookup = (state == READY) && lk_valid && !load_start;

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (load_start)
            state_nxt = LOADING;
        else if (accept && last)
            state_nxt = (dup || hit) ? ERROR : READY;
    end

    always_comb begin
        load_ready = (state == LOADING);
        tbl_ready  = (state == READY);
        tbl_error  = (state == ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            seen_addr    <= '0;
            seen_data    <= '0;
            dup          <= 1'b0;
            lk_out_valid <= 1'b0;
            out_zero     <= 1'b1;
        end else begin
            lk_out_valid <= lookup;
            if (lookup)
                out_zero <= 1'b0;
            if (load_start) begin
                cnt       <= '0;
                seen_addr <= '0;
                seen_data <= '0;
                dup       <= 1'b0;
            end else if (accept) begin
                cnt                  <= cnt + CNT_W'(1);
                seen_addr[load_addr] <= 1'b1;
                seen_data[load_data] <= 1'b1;
                dup                  <= dup | hit;
            end
        end
    end

    // The RAM has no reset, so lk_out reads as zero until the first lookup after reset.
    assign lk_out = out_zero ? '0 : ram_q;

    odo_ram64x6 u_ram (
        .clk   (clk),
        .we    (accept && !rst),
        .waddr (load_data),
        .wdata (load_addr),
        .re    (lookup && !rst),
        .raddr (lk_in),
        .rdata (ram_q)
    );

endmodule
